// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state type, wait-counter width and region compare helper.
package bus_pkg;

    localparam int WAIT_W = 4;
    localparam int CMP_W  = 32;

    typedef enum logic [2:0] {IDLE, ADDR, STROBE, WAIT, DONE} state_e;

    // I/O cycles only carry io_w meaningful address bits, so the rest are cleared before compare.
    function automatic logic region_hit(
        input logic [CMP_W-1:0] addr,
        input logic [CMP_W-1:0] base,
        input logic [CMP_W-1:0] mask,
        input logic             iom,
        input logic             region_iom,
        input int               io_w
    );
        logic [CMP_W-1:0] a;
        a = iom ? addr & ((CMP_W'(1) << io_w) - CMP_W'(1)) : addr;
        return (iom == region_iom) && (((a ^ base) & mask) == '0);
    endfunction

endpackage

// File: rtl/region_match.sv
// region_match: priority address decode; the lowest matching region index wins.
module region_match
    import bus_pkg::*;
#(
    parameter int                                   ADDR_W      = 20,
    parameter int                                   IO_W        = 16,
    parameter int                                   NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0]   REGION_BASE = '0,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0]   REGION_MASK = '0,
    parameter logic [NUM_REGIONS-1:0]               REGION_IOM  = '0,
    parameter logic [NUM_REGIONS-1:0][WAIT_W-1:0]   REGION_WAIT = '0,
    parameter logic [WAIT_W-1:0]                    MISS_WAIT   = WAIT_W'(2)
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   iom_i,
    output logic [NUM_REGIONS-1:0] cs_o,
    output logic                   hit_o,
    output logic [WAIT_W-1:0]      wait_o
);

    always_comb begin
        cs_o   = '0;
        hit_o  = 1'b0;
        wait_o = MISS_WAIT;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (region_hit(CMP_W'(addr_i), CMP_W'(REGION_BASE[r]), CMP_W'(REGION_MASK[r]),
                           iom_i, REGION_IOM[r], IO_W)) begin
                cs_o    = '0;
                cs_o[r] = 1'b1;
                hit_o   = 1'b1;
                wait_o  = REGION_WAIT[r];
            end
        end
    end

endmodule

// File: rtl/bus_cycle_decoder.sv
// bus_cycle_decoder: 8088 bus glue - address latch, chip-select decode,
// wait-state FSM driving READY, and 8286 transceiver control.
module bus_cycle_decoder
    import bus_pkg::*;
#(
    parameter int                                   ADDR_W      = 20,
    parameter int                                   IO_W        = 16,
    parameter int                                   NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0]   REGION_BASE = '0,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0]   REGION_MASK = '0,
    parameter logic [NUM_REGIONS-1:0]               REGION_IOM  = '0,
    parameter logic [NUM_REGIONS-1:0][WAIT_W-1:0]   REGION_WAIT = '0,
    parameter logic [WAIT_W-1:0]                    MISS_WAIT   = WAIT_W'(2)
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   ALE,
    input  logic [ADDR_W-1:0]      AD_A,
    input  logic                   IOM,
    input  logic                   RD_N,
    input  logic                   WR_N,
    input  logic                   DTR,
    input  logic                   DEN,
    output logic [ADDR_W-1:0]      ADDRESS,
    output logic [NUM_REGIONS-1:0] CS,
    output logic                   READY,
    output logic                   DEC_ERR,
    output logic                   XCVR_OE_N,
    output logic                   XCVR_DIR
);

    logic [NUM_REGIONS-1:0] match_cs;
    logic                   match_hit;
    logic [WAIT_W-1:0]      match_wait;

    state_e                 state_q;
    logic [ADDR_W-1:0]      address_q;
    logic [NUM_REGIONS-1:0] cs_q;
    logic [WAIT_W-1:0]      cnt_q;
    logic                   ready_q;
    logic                   dec_err_q;
    logic                   xcvr_oe_n_q;
    logic                   xcvr_dir_q;

    // Decoding the pins directly lets CS register on the ALE edge and be valid throughout ADDR.
    region_match #(
        .ADDR_W      (ADDR_W),
        .IO_W        (IO_W),
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .REGION_IOM  (REGION_IOM),
        .REGION_WAIT (REGION_WAIT),
        .MISS_WAIT   (MISS_WAIT)
    ) u_match (
        .addr_i (AD_A),
        .iom_i  (IOM),
        .cs_o   (match_cs),
        .hit_o  (match_hit),
        .wait_o (match_wait)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            address_q   <= '0;
            cs_q        <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            dec_err_q   <= 1'b0;
            xcvr_oe_n_q <= 1'b1;
            xcvr_dir_q  <= 1'b0;
        end else begin
            dec_err_q   <= 1'b0;
            xcvr_oe_n_q <= DEN || state_q == IDLE;
            xcvr_dir_q  <= DTR && state_q != IDLE;
            if (ALE && (state_q == IDLE || state_q == DONE)) begin
                state_q   <= ADDR;
                address_q <= AD_A;
                cs_q      <= match_cs;
                cnt_q     <= match_wait;
                dec_err_q <= !match_hit;
            end else begin
                case (state_q)
                    ADDR: state_q <= STROBE;
                    STROBE: begin
                        if (!RD_N || !WR_N) begin
                            dec_err_q <= !RD_N && !WR_N;
                            state_q   <= (cnt_q != '0) ? WAIT : DONE;
                            ready_q   <= cnt_q == '0;
                        end
                    end
                    WAIT: begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                        if (cnt_q <= WAIT_W'(1)) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (RD_N && WR_N) begin
                            state_q     <= IDLE;
                            cs_q        <= '0;
                            xcvr_oe_n_q <= 1'b1;
                            xcvr_dir_q  <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ADDRESS   = address_q;
    assign CS        = cs_q;
    assign READY     = ready_q;
    assign DEC_ERR   = dec_err_q;
    assign XCVR_OE_N = xcvr_oe_n_q;
    assign XCVR_DIR  = xcvr_dir_q;

endmodule

// File: tb/tb_bus_cycle_decoder.sv
// tb_bus_cycle_decoder: directed bus cycles; a negedge monitor scores each cycle against a queue.
module tb_bus_cycle_decoder;

    localparam int AW = 20;
    localparam logic [3:0][AW-1:0] BASE  = {20'h00100, 20'h0FF00, 20'h80000, 20'h00000};
    localparam logic [3:0][AW-1:0] MASK  = {20'hFFF00, 20'h0FFF0, 20'h80000, 20'hF0000};
    localparam logic [3:0]         IOMP  = 4'b0100;
    localparam logic [3:0][3:0]    WAITP = {4'd3, 4'd0, 4'd2, 4'd1};

    logic          clk = 1'b0, rst_n = 1'b0, ale = 1'b0, iom = 1'b0;
    logic          rd_n = 1'b1, wr_n = 1'b1, dtr = 1'b0, den = 1'b1;
    logic [AW-1:0] ad = '0;
    logic [AW-1:0] address;
    logic [3:0]    cs;
    logic          ready, dec_err, oe_n, dir;

    always #5 clk = ~clk;

    bus_cycle_decoder #(
        .ADDR_W(AW), .IO_W(16), .NUM_REGIONS(4),
        .REGION_BASE(BASE), .REGION_MASK(MASK), .REGION_IOM(IOMP),
        .REGION_WAIT(WAITP), .MISS_WAIT(4'd2)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .ALE(ale), .AD_A(ad), .IOM(iom),
        .RD_N(rd_n), .WR_N(wr_n), .DTR(dtr), .DEN(den),
        .ADDRESS(address), .CS(cs), .READY(ready), .DEC_ERR(dec_err),
        .XCVR_OE_N(oe_n), .XCVR_DIR(dir)
    );

    typedef struct {
        string         nm;
        logic [AW-1:0] addr;
        logic [3:0]    cs;
        int            derr;
        int            rlow;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0, n_fail = 0;
    int   rlow = 0, derr = 0;
    bit   cur_active = 0, ale_prev = 0, done_req = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic finish_txn();
        chk({cur.nm, "_ready_low"}, 32'(rlow), 32'(cur.rlow));
        chk({cur.nm, "_dec_err"}, 32'(derr), 32'(cur.derr));
        cur_active = 0;
    endtask

    // Monitor: the cycle after ALE is ADDR, where ADDRESS/CS are checked; READY-low and
    // DEC_ERR cycles are then tallied until the next ALE or the final flush.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_active = 0;
            ale_prev   = 0;
        end else begin
            if (ale_prev) begin
                if (cur_active) finish_txn();
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_cycle: got cs %0h expected no cycle", cs);
                end else begin
                    cur = q.pop_front();
                    cur_active = 1;
                    rlow = 0;
                    derr = 0;
                    chk({cur.nm, "_address"}, 32'(address), 32'(cur.addr));
                    chk({cur.nm, "_cs"}, 32'(cs), 32'(cur.cs));
                end
            end else if (done_req && cur_active) begin
                finish_txn();
            end
            if (cur_active) begin
                rlow += ready ? 0 : 1;
                derr += dec_err ? 1 : 0;
            end
            ale_prev = ale;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // mode: 0 read, 1 write, 2 both strobes low (illegal)
    task automatic bus_cycle(input string nm, input logic [AW-1:0] a, input logic io, input int mode,
                             input logic [3:0] ecs, input int ed, input int erl, input bit b2b);
        bit ok;
        q.push_back('{nm, a, ecs, ed, erl});
        ale = 1'b1; ad = a; iom = io; rd_n = 1'b1; wr_n = 1'b1;
        step();
        ale = 1'b0; den = 1'b0; dtr = (mode != 0);
        step();
        chk({nm, "_oe_n"}, 32'(oe_n), 32'(0));
        chk({nm, "_dir"}, 32'(dir), 32'(mode != 0));
        rd_n = (mode == 1); wr_n = (mode == 0);
        step();
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ready) ok = 1;
            else step();
        end
        chk({nm, "_ready_return"}, 32'(ready), 32'(1));
        if (!b2b) begin
            rd_n = 1'b1; wr_n = 1'b1; den = 1'b1; dtr = 1'b0;
            step();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish within budget");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_address", 32'(address), 32'(0));
        chk("rst_cs", 32'(cs), 32'(0));
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_dec_err", 32'(dec_err), 32'(0));
        chk("rst_oe_n", 32'(oe_n), 32'(1));
        chk("rst_dir", 32'(dir), 32'(0));
        #11 rst_n = 1'b1;
        step();
        den = 1'b0; dtr = 1'b1;
        step();
        chk("idle_oe_forced", 32'(oe_n), 32'(1));
        chk("idle_dir_forced", 32'(dir), 32'(0));
        den = 1'b1; dtr = 1'b0;
        step();

        bus_cycle("mem_rd_r1",   20'h80010, 1'b0, 0, 4'b0010, 0, 2, 1'b0);
        bus_cycle("io_wr_r2",    20'h0FF05, 1'b1, 1, 4'b0100, 0, 0, 1'b0);
        bus_cycle("io_hi_bits",  20'h3FF05, 1'b1, 0, 4'b0100, 0, 0, 1'b0);
        bus_cycle("mem_not_io",  20'h0FF05, 1'b0, 0, 4'b0001, 0, 1, 1'b0);
        bus_cycle("overlap_b2b", 20'h00100, 1'b0, 0, 4'b0001, 0, 1, 1'b1);
        bus_cycle("b2b_second",  20'h80010, 1'b0, 1, 4'b0010, 0, 2, 1'b0);
        bus_cycle("miss",        20'h40000, 1'b0, 0, 4'b0000, 1, 2, 1'b0);
        bus_cycle("illegal",     20'h80010, 1'b0, 2, 4'b0010, 1, 2, 1'b0);

        // Abort a cycle in WAIT with an asynchronous reset.
        q.push_back('{"rst_abort", 20'h80010, 4'b0010, 0, 0});
        ale = 1'b1; ad = 20'h80010; iom = 1'b0;
        step();
        ale = 1'b0; den = 1'b0;
        step();
        rd_n = 1'b0;
        step();
        chk("abort_in_wait", 32'(ready), 32'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'(1));
        chk("abort_cs", 32'(cs), 32'(0));
        chk("abort_oe_n", 32'(oe_n), 32'(1));
        rd_n = 1'b1; den = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        bus_cycle("after_reset", 20'h80020, 1'b0, 0, 4'b0010, 0, 2, 1'b0);

        done_req = 1;
        step();
        step();
        chk("queue_empty", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_cycle_decoder.md
Name: bus_cycle_decoder

Overview:
Parametrised successor to the fixed two-memory/two-I/O chip-select glue around the 8088 bus. Latches the multiplexed address on ALE and decodes it against NUM_REGIONS parameter-defined regions, each selecting memory or I/O space. Runs a per-cycle FSM that inserts per-region wait states and drives READY back to the processor. Also drives the 8286 transceiver controls and flags accesses that hit no region.

Parameters:
ADDR_W, 20, latched address width (memory space; I/O regions compare low IO_W bits only)
IO_W, 16, I/O address width
NUM_REGIONS, 4, number of chip-select regions (1..16)
REGION_BASE, {NUM_REGIONS{ADDR_W'h0}}, packed array, base address per region
REGION_MASK, {NUM_REGIONS{ADDR_W'h0}}, packed array, 1 bits participate in compare
REGION_IOM, NUM_REGIONS'b0, bit r = 1 for an I/O region, 0 for memory
REGION_WAIT, {NUM_REGIONS{4'd0}}, packed 4-bit wait-state count per region
MISS_WAIT, 4'd2, wait states applied to an unmapped access

Ports:
CLK  in  1  bus clock
RESET_N  in  1  asynchronous active-low reset
ALE  in  1  address latch enable
AD_A  in  ADDR_W  multiplexed address/data pins as seen at T1
IOM  in  1  1 = I/O cycle, 0 = memory cycle
RD_N  in  1  read strobe, active low
WR_N  in  1  write strobe, active low
DTR  in  1  transceiver direction (1 = CPU drives)
DEN  in  1  data enable, active low
ADDRESS  out  ADDR_W  latched address
CS  out  NUM_REGIONS  one-hot chip selects
READY  out  1  ready to CPU
DEC_ERR  out  1  one-cycle pulse: current cycle hit no region
XCVR_OE_N  out  1  transceiver output enable, active low
XCVR_DIR  out  1  transceiver direction

Behaviour:
- Reset (async, RESET_N low): ADDRESS=0, CS=0, READY=1, DEC_ERR=0, XCVR_OE_N=1, XCVR_DIR=0, FSM=IDLE, wait counter=0. Reset mid-cycle aborts the cycle immediately.
- ADDRESS and IOM are registered on the rising CLK edge where ALE=1; ALE ignored outside IDLE/DONE.
- Decode is registered, one cycle after ALE. Region r hits when REGION_IOM[r]==IOM and ((ADDRESS ^ REGION_BASE[r]) & REGION_MASK[r])==0. For I/O, bits above IO_W-1 are forced to 0 before compare. Overlapping hits: lowest index wins, so CS is always one-hot or zero.
- FSM states: IDLE, ADDR, STROBE, WAIT, DONE.
  - IDLE -> ADDR on ALE.
  - ADDR: decode result loaded; counter = REGION_WAIT[hit] or MISS_WAIT. -> STROBE.
  - STROBE: when RD_N=0 or WR_N=0, go to WAIT if counter>0, else DONE. READY=0 from entry to WAIT until DONE.
  - WAIT: counter decrements each cycle; at 0 -> DONE.
  - DONE: READY=1. When RD_N and WR_N are both 1 -> IDLE. If ALE=1 -> ADDR (back-to-back cycle).
  - RD_N and WR_N both low is illegal: treat as write, and DEC_ERR pulses.
- CS is asserted from ADDR through DONE and deasserts on the return to IDLE or ADDR.
- DEC_ERR pulses for one cycle in ADDR when there is no hit; the cycle still completes after MISS_WAIT wait states with CS=0.
- XCVR_OE_N = DEN and XCVR_DIR = DTR, registered (one-cycle latency). Both are forced to 1/0 in IDLE.
- With counter width 4, the maximum is 15 wait states; no wrap occurs.

Decomposition:
- Package bus_pkg: state enum (IDLE, ADDR, STROBE, WAIT, DONE), WAIT_W=4 constant, and a region-hit function.
- One sub-module, region_match: combinational priority match returning a one-hot vector, a hit flag and the wait count. The FSM and latches stay in the top.

Test Plan:
- Reset: RESET_N low mid-WAIT -> READY=1, CS=0, XCVR_OE_N=1 in the same cycle; the next ALE starts a clean cycle.
- Memory read at 0x80010 with region1 = base 0x80000, mask 0x80000, wait 2 -> CS=4'b0010 one cycle after ALE; READY low exactly 2 cycles after RD_N falls.
- I/O write at 0xFF05 with region2 = base 0xFF00, mask 0xFFF0, IOM=1, wait 0 -> CS=4'b0100 and READY never drops.
- Overlap: regions 0 and 3 both match 0x00100 -> CS=4'b0001 only.
- Miss: memory access at 0x40000 with no mapped region -> DEC_ERR single pulse, CS=0, READY low for 2 cycles, then the cycle ends.
- Back-to-back: ALE asserted in DONE -> direct transition to ADDR and the new CS, with no idle cycle.
